// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: session controller for a programmable serial bit-pattern detector.
// A session is launched by start, which latches the pattern, length, match target
// and timeout. The session then counts Mealy matches on the qualified stream w/w_valid
// and ends on the target being reached, on timeout, or on abort.
// Optional build macro: SEQ_DET_NO_OVERLAP_EN. When it is defined, matches do not
// overlap: each counted match restarts the fill count.
//
// state | meaning
// IDLE  | waiting for start; config not yet latched
// RUN   | detecting and counting matches, timer running
// DONE  | match target reached; status and match_cnt held
// TMO   | timeout expired; status and match_cnt held
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] match_target,
  input  logic [TMO_W-1:0] timeout,
  input  logic             w,
  input  logic             w_valid,
  input  logic             abort,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_t;

  state_t           state_q, state_d;
  // The oldest history bit is never compared, because the current bit w completes
  // the window. Only PAT_W-1 bits of history are kept.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_flag_q, tmo_flag_d;

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             fill_ok;
  logic             pat_hit;
  logic             z_int;
  logic             final_hit;
  logic             tmo_hit;
  logic             cfg_ok;

  // Match window, Mealy match pulse and the session exit conditions
  always_comb begin
    window = {hist_q, w};
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    fill_ok   = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    pat_hit   = ((window ^ pat_q) & mask) == '0;
    z_int     = rst & busy_q & w_valid & fill_ok & pat_hit;
    final_hit = z_int & (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, tgt_q});
    tmo_hit   = (tmo_q != '0) & (timer_q == (tmo_q - TMO_W'(1)));
    cfg_ok    = (pat_len != '0) & (pat_len <= LEN_W'(PAT_W)) & (match_target != '0);
  end

  // Next-state, datapath and registered status decode
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    tmo_d     = tmo_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (w_valid) begin
            hist_d = window[PAT_W-2:0];
            if (fill_q != LEN_W'(PAT_W)) fill_d = fill_q + LEN_W'(1);
          end
          if (z_int) begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_DET_NO_OVERLAP_EN
            fill_d = '0;
`endif
          end
          timer_d = timer_q + TMO_W'(1);
          // A final match beats a timeout in the same cycle
          if (final_hit)    state_d = S_DONE;
          else if (tmo_hit) state_d = S_TMO;
        end
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          if (cfg_ok) begin
            pat_d   = pattern;
            len_d   = pat_len;
            tgt_d   = match_target;
            tmo_d   = timeout;
            hist_d  = '0;
            fill_d  = '0;
            timer_d = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
    endcase
    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    tmo_flag_d = (state_d == S_TMO);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hist_q     <= '0;
      fill_q     <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      tgt_q      <= '0;
      tmo_q      <= '0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      tgt_q      <= tgt_d;
      tmo_q      <= tmo_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign z         = z_int;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = tmo_flag_q;
  assign cfg_err   = cfg_err_q;

endmodule
